// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: op codes, FSM states
// and small op-classification helpers.
package ex_muldiv_ctrl_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction
endpackage

// File: rtl/ex_muldiv_ctrl_shift_unit.sv
// One radix-2 iteration per step over a 2*WIDTH accumulator: shift-add multiply
// (accumulator shifts right) or restoring divide (accumulator shifts left).
module ex_muldiv_ctrl_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_init,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_top;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_next;

  // Divide: the shifted partial remainder needs WIDTH+1 bits before the trial subtract.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_top[WIDTH-1:0] - r_opnd;
    w_next     = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (i_div) begin
      if (w_div_top >= {1'b0, r_opnd})
        w_next = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
      else
        w_next = {w_div_top[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_acc  <= {{WIDTH{1'b0}}, i_init};
      r_opnd <= i_opnd;
    end else if (i_step) begin
      r_acc  <= w_next;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: stalls the pipe while
// busy and writes the 64-bit result into HI/LO.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int               WIDTH   = MD_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          r_state;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_lo, r_neg_hi, r_busy, r_done, r_div_zero;
  logic               w_is_div, w_is_signed;
  logic [2*WIDTH-1:0] w_acc, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_hi, w_fix_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign w_is_div    = md_is_div(r_op);
  assign w_is_signed = md_is_signed(r_op);

  ex_muldiv_ctrl_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (r_state == ST_PREP),
    .i_step (r_state == ST_RUN),
    .i_div  (w_is_div),
    .i_init (mag(r_a, w_is_signed)),
    .i_opnd (mag(r_b, w_is_signed)),
    .o_acc  (w_acc)
  );

  // Product is negated as a whole; quotient and remainder carry independent signs.
  always_comb begin
    w_prod   = r_neg_lo ? -w_acc : w_acc;
    w_quo    = r_neg_lo ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    w_rem    = r_neg_hi ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    w_fix_hi = w_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_is_div ? w_quo : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= MD_MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (cancel) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= start;
          if (start) begin
            r_state    <= ST_PREP;
            r_op       <= md_op_e'(op);
            r_a        <= data_a;
            r_b        <= data_b;
            r_div_zero <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PREP: begin
          r_neg_lo <= w_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_hi <= w_is_signed & r_a[WIDTH-1];
          if (w_is_div && (r_b == '0)) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_hi       <= r_a;
            r_lo       <= DIV0_LO;
            r_div_zero <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_cnt   <= CNT_W'(WIDTH - 1);
          end
        end
        ST_RUN: begin
          if (r_cnt == '0) r_state <= ST_FIX;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_FIX: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign stall    = r_busy | (start & (r_state == ST_IDLE));
  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: directed ops push expected HI/LO/div_zero/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_a = '0, data_b = '0;
  logic        cancel = 1'b0;
  logic        stall, busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_ctrl #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_a(data_a), .data_b(data_b),
    .cancel(cancel), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (q.size() == 0) begin
        chk("done_without_request", 64'(done), 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_zero", 64'(div_zero), 64'(mon_e.dz));
        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; returns just after the accepting rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int lat);
    exp_t e;
    op = o; data_a = a; data_b = b; start = 1'b1;
    #1;
    if (!done) chk("stall_on_start", 64'(stall), 64'd1);
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.lat = lat; e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int exp_busy);
    int n = 0;
    int nb = 0;
    do begin
      @(negedge clk);
      if (busy) nb++;
      n++;
    end while (!done && n < 200);
    if (!done) chk("done_timeout", 64'(done), 64'd1);
    chk("busy_cycles", 64'(nb), 64'(exp_busy));
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34);
    wait_done(34);
    @(negedge clk);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34);
    wait_done(34);
    @(negedge clk);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, 0, 34);
    wait_done(34);
    @(negedge clk);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
    wait_done(34);
    @(negedge clk);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 0, 34);
    wait_done(34);
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 34);
    wait_done(34);
    // back-to-back: accepted in the DONE cycle
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 0, 34);
    wait_done(34);
    @(negedge clk);
    issue(2'b11, 32'h0000_1234, 32'h0, 1, 32'h0000_1234, 32'hFFFF_FFFF, 1, 1);
    wait_done(1);
    @(negedge clk);
    chk("dz_held", 64'(div_zero), 64'd1);
    issue(2'b01, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 34);
    @(negedge clk);
    chk("dz_cleared", 64'(div_zero), 64'd0);
    wait_done(33);

    // start while busy ignored, then cancel mid-run
    @(negedge clk);
    issue(2'b00, 32'd5, 32'd5, 0, '0, '0, 0, 0);
    repeat (3) @(negedge clk);
    op = 2'b11; data_a = 32'd1; data_b = 32'd0; start = 1'b1;
    #1 chk("stall_busy", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hilo", {hi, lo}, {32'd0, 32'd42});
    repeat (40) @(negedge clk);
    chk("cancel_no_done_busy", 64'(busy), 64'd0);

    // cancel and start together in IDLE
    start = 1'b1; cancel = 1'b1; op = 2'b01; data_a = 32'd3; data_b = 32'd3;
    #1 chk("stall_cancel_start", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-RUN
    issue(2'b01, 32'd9, 32'd9, 0, '0, '0, 0, 0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_stall", 64'(stall), 64'd0);
    chk("areset_hilo", {hi, lo}, 64'd0);
    chk("areset_done_dz", {62'd0, done, div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 34);
    wait_done(34);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
